// File: rtl/la_pkg.sv
// Shared types and constants for the capture-to-memory burst writer.
package la_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_DATA,
    S_BURST,
    S_DONE
  } mbw_state_t;

  localparam int         MM_DATA_W = 32;
  localparam logic [3:0] MM_BE_ALL = 4'hF;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; dout always presents the oldest entry.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && (count != '0);
  // A pop frees a slot in the same cycle, so a full FIFO may still take a push.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (do_pop && !do_push) count <= count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mm_burst_writer.sv
// Avalon-MM burst-write master draining the capture stream into memory.
//   state       | meaning
//   S_IDLE      | waiting for start
//   S_WAIT_DATA | buffering until the next burst is fully in the FIFO
//   S_BURST     | presenting burst beats to the slave
//   S_DONE      | transfer complete, done pulses next cycle
module mm_burst_writer
  import la_pkg::*;
#(
  parameter int ADDR_SIZE  = 32,
  parameter int BURST_LEN  = 16,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                           mm_clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           abort,
  input  logic [ADDR_SIZE-1:0]           cfg_base,
  input  logic [31:0]                    cfg_words,
  output logic                           busy,
  output logic                           done,
  output logic [31:0]                    words_written,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [MM_DATA_W-1:0]           in_data,
  output logic [ADDR_SIZE-1:0]           mm_address,
  output logic [$clog2(BURST_LEN):0]     mm_burstcount,
  output logic                           mm_write,
  output logic [MM_DATA_W-1:0]           mm_writedata,
  output logic [3:0]                     mm_byteenable,
  input  logic                           mm_waitrequest
);

  localparam int BC_W  = $clog2(BURST_LEN) + 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  mbw_state_t            state;
  logic [ADDR_SIZE-1:0]  cur_addr;
  logic [31:0]           remaining;
  logic [31:0]           accept_left;
  logic                  abort_pend;
  logic [BC_W-1:0]       beats_left;
  logic [BC_W-1:0]       blen;
  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_full;
  logic                  push;
  logic                  beat;
  logic                  flush;
  logic                  unused_base_lsbs;

  assign unused_base_lsbs = ^cfg_base[1:0];

  assign busy          = (state != S_IDLE);
  assign in_ready      = busy && !fifo_full && (accept_left != '0) && !abort_pend;
  assign push          = in_valid && in_ready;
  assign beat          = mm_write && !mm_waitrequest;
  assign flush         = ((state == S_IDLE) && start) || ((state == S_WAIT_DATA) && abort);
  assign mm_byteenable = MM_BE_ALL;
  assign blen          = (remaining >= 32'(BURST_LEN)) ? BC_W'(BURST_LEN) : BC_W'(remaining);

  sync_fifo #(
    .WIDTH (MM_DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (mm_clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .din   (in_data),
    .pop   (beat),
    .dout  (mm_writedata),
    .full  (fifo_full),
    .count (fifo_count)
  );

  always_ff @(posedge mm_clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cur_addr      <= '0;
      remaining     <= '0;
      accept_left   <= '0;
      abort_pend    <= 1'b0;
      beats_left    <= '0;
      words_written <= '0;
      done          <= 1'b0;
      mm_write      <= 1'b0;
      mm_address    <= '0;
      mm_burstcount <= '0;
    end else begin
      done <= 1'b0;
      if (push) accept_left   <= accept_left - 32'd1;
      if (beat) words_written <= words_written + 32'd1;

      case (state)
        S_IDLE: begin
          if (start) begin
            cur_addr      <= {cfg_base[ADDR_SIZE-1:2], 2'b00};
            remaining     <= cfg_words;
            accept_left   <= cfg_words;
            words_written <= '0;
            abort_pend    <= 1'b0;
            state         <= (cfg_words == '0) ? S_DONE : S_WAIT_DATA;
          end
        end

        S_WAIT_DATA: begin
          if (abort) begin
            state <= S_IDLE;
          end else if (32'(fifo_count) >= 32'(blen)) begin
            mm_address    <= cur_addr;
            mm_burstcount <= blen;
            beats_left    <= blen;
            mm_write      <= 1'b1;
            state         <= S_BURST;
          end
        end

        S_BURST: begin
          if (abort) abort_pend <= 1'b1;
          if (beat) begin
            beats_left <= beats_left - BC_W'(1);
            // mm_burstcount still holds this burst's length for the bookkeeping below.
            if (beats_left == BC_W'(1)) begin
              mm_write   <= 1'b0;
              abort_pend <= 1'b0;
              cur_addr   <= cur_addr + ADDR_SIZE'({mm_burstcount, 2'b00});
              remaining  <= remaining - 32'(mm_burstcount);
              if (remaining == 32'(mm_burstcount)) state <= S_DONE;
              else if (abort_pend || abort)       state <= S_IDLE;
              else                                state <= S_WAIT_DATA;
            end
          end
        end

        S_DONE: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
